// File: rtl/riscuinho_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// riscuinho_seq_ctrl_if
//
// Memory-side handshake bundle for the RISCuinho sequencing controller.
//
// Signals:
//   imem_req  instruction fetch request (controller -> imem)
//   imem_ack  fetch done, same-cycle ack allowed (imem -> controller)
//   instr     32-bit instruction word, valid with imem_ack (imem -> controller)
//   dmem_req  data memory request (controller -> dmem)
//   dmem_we   1 = store, 0 = load, valid while dmem_req=1 (controller -> dmem)
//   dmem_ack  data access done (dmem -> controller)
//
// Modports:
//   master  the sequencing controller
//   slave   the memory model / memory subsystem
// -----------------------------------------------------------------------------
interface riscuinho_seq_ctrl_if;
   logic        imem_req;
   logic        imem_ack;
   logic [31:0] instr;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_ack;

   modport master (
      output imem_req,
      input  imem_ack,
      input  instr,
      output dmem_req,
      output dmem_we,
      input  dmem_ack
   );

   modport slave (
      input  imem_req,
      output imem_ack,
      output instr,
      input  dmem_req,
      input  dmem_we,
      output dmem_ack
   );
endinterface

// File: rtl/riscuinho_seq_ctrl.sv
// -----------------------------------------------------------------------------
// riscuinho_seq_ctrl
//
// Multi-cycle sequencing controller for the RISCuinho datapath. Walks each
// instruction through FETCH, DECODE, EXEC, (MEM), WB and drives the datapath
// strobes and the memory request handshakes.
//
// Parameters:
//   ACK_TIMEOUT  max request cycles waited for a memory ack (0 = no timeout)
//
// Ports:
//   clk          core clock, rising edge
//   rst          asynchronous reset, active low
//   run          1 = keep executing; 0 = stop after the current instruction
//   clr_err      leaves ERROR (only looked at while in ERROR)
//   mem          memory handshake bundle (master side)
//   ir_we        latch instr into the datapath IR (FETCH & imem_ack)
//   pc_we        PC update strobe (WB)
//   rf_we        register file write strobe (WB, writing class, rd != 0)
//   rd_data_sel  writeback source: 00 ALU, 01 memory, 10 PC+4, 11 immediate
//   state        current state for the monitor
//   instret      retired instruction count, wraps at 2^32
//   error_code   00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout
// -----------------------------------------------------------------------------
module riscuinho_seq_ctrl #(
   parameter int unsigned ACK_TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run,
   input  logic                 clr_err,
   riscuinho_seq_ctrl_if.master mem,
   output logic                 ir_we,
   output logic                 pc_we,
   output logic                 rf_we,
   output logic [1:0]           rd_data_sel,
   output logic [2:0]           state,
   output logic [31:0]          instret,
   output logic [1:0]           error_code
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      ERROR  = 3'd6
   } state_t;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [1:0] RD_ALU = 2'b00;
   localparam logic [1:0] RD_MEM = 2'b01;
   localparam logic [1:0] RD_PC4 = 2'b10;
   localparam logic [1:0] RD_IMM = 2'b11;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_IMEM    = 2'b10;
   localparam logic [1:0] ERR_DMEM    = 2'b11;

   // The counter only has to reach ACK_TIMEOUT-1: the last request cycle is
   // detected while it still holds that value.
   localparam int unsigned CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
   localparam bit          TIMEOUT_EN = (ACK_TIMEOUT != 0);
   localparam logic [CNT_W-1:0] WAIT_LAST =
      (ACK_TIMEOUT == 0) ? '0 : CNT_W'(ACK_TIMEOUT - 1);

   state_t           state_reg,   state_next;
   logic [CNT_W-1:0] wait_reg,    wait_next;
   logic [6:0]       opcode_reg,  opcode_next;
   logic [4:0]       rd_reg,      rd_next;
   logic [1:0]       sel_reg,     sel_next;
   logic [1:0]       err_reg,     err_next;
   logic [31:0]      instret_reg, instret_next;

   // Decoded view of the latched opcode.
   logic       op_legal;
   logic       op_mem;
   logic       op_store;
   logic       op_writes_rd;
   logic [1:0] op_sel;

   // Only opcode and rd are kept here; the datapath owns the full IR.
   logic instr_hi_unused;
   assign instr_hi_unused = ^{mem.instr[31:12]};

   always_comb begin
      op_legal     = 1'b1;
      op_mem       = 1'b0;
      op_store     = 1'b0;
      op_writes_rd = 1'b1;
      op_sel       = RD_ALU;
      case (opcode_reg)
         OPC_LOAD: begin
            op_mem = 1'b1;
            op_sel = RD_MEM;
         end
         OPC_STORE: begin
            op_mem       = 1'b1;
            op_store     = 1'b1;
            op_writes_rd = 1'b0;
         end
         OPC_BRANCH: begin
            op_writes_rd = 1'b0;
         end
         OPC_JAL, OPC_JALR: begin
            op_sel = RD_PC4;
         end
         OPC_LUI: begin
            op_sel = RD_IMM;
         end
         OPC_OP, OPC_OPIMM, OPC_AUIPC, OPC_SYSTEM: begin
            op_sel = RD_ALU;
         end
         default: begin
            op_legal     = 1'b0;
            op_writes_rd = 1'b0;
         end
      endcase
   end

   // Next-state logic. The wait counter defaults to zero, so it is always
   // clear on entry to FETCH or MEM and only advances on ack-less cycles there.
   always_comb begin
      state_next   = state_reg;
      wait_next    = '0;
      opcode_next  = opcode_reg;
      rd_next      = rd_reg;
      sel_next     = sel_reg;
      err_next     = err_reg;
      instret_next = instret_reg;
      ir_we        = 1'b0;

      case (state_reg)
         IDLE: begin
            sel_next = RD_ALU;
            if (run) begin
               state_next = FETCH;
            end
         end
         FETCH: begin
            if (mem.imem_ack) begin
               ir_we       = 1'b1;
               opcode_next = mem.instr[6:0];
               rd_next     = mem.instr[11:7];
               state_next  = DECODE;
            end else if (TIMEOUT_EN && (wait_reg == WAIT_LAST)) begin
               err_next   = ERR_IMEM;
               state_next = ERROR;
            end else if (TIMEOUT_EN) begin
               wait_next = wait_reg + 1'b1;
            end
         end
         DECODE: begin
            if (!op_legal) begin
               err_next   = ERR_ILLEGAL;
               state_next = ERROR;
            end else begin
               sel_next   = op_sel;
               state_next = EXEC;
            end
         end
         EXEC: begin
            state_next = op_mem ? MEM : WB;
         end
         MEM: begin
            if (mem.dmem_ack) begin
               state_next = WB;
            end else if (TIMEOUT_EN && (wait_reg == WAIT_LAST)) begin
               err_next   = ERR_DMEM;
               sel_next   = RD_ALU;
               state_next = ERROR;
            end else if (TIMEOUT_EN) begin
               wait_next = wait_reg + 1'b1;
            end
         end
         WB: begin
            instret_next = instret_reg + 32'd1;
            sel_next     = RD_ALU;
            state_next   = run ? FETCH : IDLE;
         end
         ERROR: begin
            sel_next = RD_ALU;
            if (clr_err) begin
               err_next   = ERR_NONE;
               state_next = IDLE;
            end
         end
         default: begin
            sel_next   = RD_ALU;
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= IDLE;
         wait_reg    <= '0;
         opcode_reg  <= '0;
         rd_reg      <= '0;
         sel_reg     <= RD_ALU;
         err_reg     <= ERR_NONE;
         instret_reg <= '0;
      end else begin
         state_reg   <= state_next;
         wait_reg    <= wait_next;
         opcode_reg  <= opcode_next;
         rd_reg      <= rd_next;
         sel_reg     <= sel_next;
         err_reg     <= err_next;
         instret_reg <= instret_next;
      end
   end

   // Requests and strobes come straight from the registered state, so an
   // asynchronous reset drops them immediately.
   assign mem.imem_req = (state_reg == FETCH);
   assign mem.dmem_req = (state_reg == MEM);
   assign mem.dmem_we  = (state_reg == MEM) && op_store;
   assign pc_we        = (state_reg == WB);
   assign rf_we        = (state_reg == WB) && op_writes_rd && (rd_reg != 5'd0);
   assign rd_data_sel  = sel_reg;
   assign state        = state_reg;
   assign instret      = instret_reg;
   assign error_code   = err_reg;

endmodule

// File: tb/tb_riscuinho_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_riscuinho_seq_ctrl
//
// Self-checking bench for riscuinho_seq_ctrl. Each instruction is expanded
// into its expected cycle-by-cycle trace from the instruction class, the
// memory latencies and the run level at WB. Inputs that the controller must
// ignore in a given cycle are randomized.
// -----------------------------------------------------------------------------
module tb_riscuinho_seq_ctrl;
   localparam int T = 15;

   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OPIMM  = 7'b0010011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] SYSTEM = 7'b1110011;

   logic        clk     = 1'b0;
   logic        rst     = 1'b0;
   logic        run     = 1'b0;
   logic        clr_err = 1'b0;
   logic        ir_we, pc_we, rf_we;
   logic [1:0]  rd_data_sel, error_code;
   logic [2:0]  state;
   logic [31:0] instret;

   int          checks   = 0;
   int          failures = 0;
   int          txn      = 0;
   logic [31:0] exp_instret = 32'd0;
   logic [6:0]  legal_tbl [10];

   riscuinho_seq_ctrl_if bus();

   riscuinho_seq_ctrl #(.ACK_TIMEOUT(T)) dut (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .clr_err     (clr_err),
      .mem         (bus),
      .ir_we       (ir_we),
      .pc_we       (pc_we),
      .rf_we       (rf_we),
      .rd_data_sel (rd_data_sel),
      .state       (state),
      .instret     (instret),
      .error_code  (error_code)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Packed output vector: state, imem_req, dmem_req, dmem_we, ir_we, pc_we,
   // rf_we, rd_data_sel, error_code.
   function automatic logic [31:0] pk(input logic [2:0] st, input logic ireq, input logic dreq,
                                      input logic dwe, input logic irw, input logic pcw,
                                      input logic rfw, input logic [1:0] sel, input logic [1:0] ec);
      return {19'd0, st, ireq, dreq, dwe, irw, pcw, rfw, sel, ec};
   endfunction

   function automatic logic [31:0] observed();
      return {19'd0, state, bus.imem_req, bus.dmem_req, bus.dmem_we,
              ir_we, pc_we, rf_we, rd_data_sel, error_code};
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic bit is_legal(input logic [6:0] o);
      for (int i = 0; i < 10; i++) begin
         if (legal_tbl[i] == o) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic [1:0] sel_of(input logic [6:0] o);
      if (o == LOAD) return 2'b01;
      if (o == JAL || o == JALR) return 2'b10;
      if (o == LUI) return 2'b11;
      return 2'b00;
   endfunction

   function automatic bit writes_rd(input logic [6:0] o);
      return is_legal(o) && (o != STORE) && (o != BRANCH);
   endfunction

   // One clock cycle: drive at the falling edge, check 1 ns later.
   task automatic step(input string tag, input logic [31:0] exp, input logic iack,
                       input logic dack, input logic run_v, input logic clr_v,
                       input logic [31:0] iw);
      @(negedge clk);
      bus.imem_ack = iack;
      bus.dmem_ack = dack;
      run          = run_v;
      clr_err      = clr_v;
      bus.instr    = iw;
      #1;
      check_val(tag, observed(), exp);
      check_val({tag, "_instret"}, instret, exp_instret);
   endtask

   // Entered with the controller in ERROR; leaves it heading into FETCH.
   task automatic error_phase(input logic [1:0] ec);
      int n;
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++)
         step("error_hold", pk(3'd6, 0, 0, 0, 0, 0, 0, 2'b00, ec), rb(), rb(), rb(), 1'b0, $urandom);
      step("error_clr", pk(3'd6, 0, 0, 0, 0, 0, 0, 2'b00, ec), rb(), rb(), rb(), 1'b1, $urandom);
      step("idle_post_err", pk(3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00), rb(), rb(), 1'b1, rb(), $urandom);
   endtask

   // One instruction, entered with the controller in FETCH; leaves it
   // heading into FETCH again. ilat/dlat are wait cycles before the ack;
   // a latency of T or more never acks. run_mode: 0/1 fixed level at WB,
   // 2 random.
   task automatic do_instr(input logic [6:0] opc, input logic [4:0] rd, input int ilat,
                           input int dlat, input int run_mode);
      logic [31:0] iw;
      logic [1:0]  sel;
      logic        st, mem_op, rfw, r;
      int          n;
      iw        = $urandom;
      iw[6:0]   = opc;
      iw[11:7]  = rd;
      sel       = sel_of(opc);
      st        = (opc == STORE);
      mem_op    = (opc == LOAD) || st;
      rfw       = writes_rd(opc) && (rd != 5'd0);
      txn++;
      $display("txn %0d opc=%b rd=%0d ilat=%0d dlat=%0d instret=%0d",
               txn, opc, rd, ilat, dlat, exp_instret);

      if (ilat >= T) begin
         for (int k = 0; k < T; k++)
            step("fetch_wait", pk(3'd1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00), 1'b0, rb(), rb(), rb(), $urandom);
         error_phase(2'b10);
         return;
      end
      for (int k = 0; k < ilat; k++)
         step("fetch_wait", pk(3'd1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00), 1'b0, rb(), rb(), rb(), $urandom);
      step("fetch_ack", pk(3'd1, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00), 1'b1, rb(), rb(), rb(), iw);
      step("decode", pk(3'd2, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00), rb(), rb(), rb(), rb(), $urandom);
      if (!is_legal(opc)) begin
         error_phase(2'b01);
         return;
      end
      step("exec", pk(3'd3, 0, 0, 0, 0, 0, 0, sel, 2'b00), rb(), rb(), rb(), rb(), $urandom);
      if (mem_op) begin
         if (dlat >= T) begin
            for (int k = 0; k < T; k++)
               step("mem_wait", pk(3'd4, 0, 1, st, 0, 0, 0, sel, 2'b00), rb(), 1'b0, rb(), rb(), $urandom);
            error_phase(2'b11);
            return;
         end
         for (int k = 0; k < dlat; k++)
            step("mem_wait", pk(3'd4, 0, 1, st, 0, 0, 0, sel, 2'b00), rb(), 1'b0, rb(), rb(), $urandom);
         step("mem_ack", pk(3'd4, 0, 1, st, 0, 0, 0, sel, 2'b00), rb(), 1'b1, rb(), rb(), $urandom);
      end
      r = (run_mode == 2) ? ($urandom_range(0, 3) != 0) : (run_mode != 0);
      step("wb", pk(3'd5, 0, 0, 0, 0, 1, rfw, sel, 2'b00), rb(), rb(), r, rb(), $urandom);
      exp_instret = exp_instret + 32'd1;
      if (!r) begin
         n = $urandom_range(0, 2);
         for (int k = 0; k < n; k++)
            step("idle_stop", pk(3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00), rb(), rb(), 1'b0, rb(), $urandom);
         step("idle_go", pk(3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00), rb(), rb(), 1'b1, rb(), $urandom);
      end
   endtask

   initial begin
      logic [31:0] iw;
      logic [6:0]  opc;
      int          p, ilat, dlat;

      legal_tbl = '{LOAD, STORE, BRANCH, JAL, JALR, OP, OPIMM, LUI, AUIPC, SYSTEM};
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      bus.instr    = 32'd0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check_val("reset_outputs", observed(), pk(3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
      check_val("reset_instret", instret, 32'd0);
      rst = 1'b1;
      step("idle_start", pk(3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00), 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);

      // Directed cases
      do_instr(OPIMM, 5'd1, 0, 0, 1);      // ADDI, zero-wait
      do_instr(LOAD,  5'd5, 0, 3, 1);      // LW x5, 3 data wait cycles
      do_instr(STORE, 5'd2, 0, 0, 1);      // SW
      do_instr(OPIMM, 5'd0, 0, 0, 1);      // ADDI to x0: no rf_we
      do_instr(7'h7F, 5'd0, 0, 0, 1);      // illegal opcode
      do_instr(OPIMM, 5'd3, T, 0, 1);      // imem timeout
      do_instr(LOAD,  5'd4, 0, T, 1);      // dmem timeout
      do_instr(OP,    5'd6, T - 1, 0, 1);  // ack in the last allowed fetch cycle
      do_instr(STORE, 5'd7, 0, T - 1, 1);  // ack in the last allowed mem cycle
      do_instr(JAL,   5'd1, 1, 0, 0);      // run=0 at WB -> IDLE
      do_instr(LUI,   5'd9, 2, 0, 1);

      // Asynchronous reset while in MEM
      iw = {20'h12345, 5'd7, LOAD};
      step("r_fetch", pk(3'd1, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00), 1'b1, rb(), rb(), rb(), iw);
      step("r_decode", pk(3'd2, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00), rb(), rb(), rb(), rb(), $urandom);
      step("r_exec", pk(3'd3, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00), rb(), rb(), rb(), rb(), $urandom);
      step("r_mem", pk(3'd4, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00), rb(), 1'b0, rb(), rb(), $urandom);
      @(negedge clk);
      bus.dmem_ack = 1'b0;
      rst = 1'b0;
      #1;
      exp_instret = 32'd0;
      check_val("rst_mid_mem", observed(), pk(3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
      check_val("rst_mid_mem_instret", instret, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      step("idle_release", pk(3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00), rb(), rb(), 1'b1, rb(), $urandom);

      // Randomized instruction stream
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 10) == 10) begin
            opc = 7'($urandom);
            while (is_legal(opc)) opc = 7'($urandom);
         end else begin
            opc = legal_tbl[$urandom_range(0, 9)];
         end
         p    = $urandom_range(0, 19);
         ilat = (p == 0) ? T : (p == 1) ? T - 1 : $urandom_range(0, 3);
         p    = $urandom_range(0, 19);
         dlat = (p == 0) ? T : (p == 1) ? T - 1 : $urandom_range(0, 3);
         do_instr(opc, 5'($urandom), ilat, dlat, 2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
